// File: rtl/ipr_write_arb.sv
// ipr_write_arb
// Round-robin arbiter sharing one IPR write port among NUM_REQ core-side
// write requesters. A granted requester keeps the port for a bulk of up to
// BULK_NUMBER words, so its words land contiguously in the FIFO. A watchdog
// takes the port back from an owner that stops requesting.
// Write-clock domain only; synchronous active-high reset.

module ipr_write_arb #(
    parameter int NUM_REQ        = 4,
    parameter int DSIZE          = 32,
    parameter int BULK_NUMBER    = 10,
    parameter int WATCHDOG_LIMIT = 100,
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = $clog2(BULK_NUMBER + 1),
    localparam int WW = $clog2(WATCHDOG_LIMIT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ-1:0]       we_i,
    input  logic [NUM_REQ-1:0]       last_i,
    input  logic [NUM_REQ*DSIZE-1:0] wdata_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       rvalid_o,
    output logic                     ipr_req_o,
    output logic                     ipr_we_o,
    output logic [DSIZE-1:0]         ipr_wdata_o,
    input  logic                     ipr_gnt_i,
    input  logic                     ipr_rvalid_i,
    output logic [OW-1:0]            owner_o,
    output logic                     busy_o,
    output logic                     timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Registered state
    state_t          state_r;
    logic [OW-1:0]   owner_r;
    logic [OW-1:0]   last_owner_r;
    logic [CW-1:0]   word_cnt_r;
    logic [WW-1:0]   wd_cnt_r;

    // Next-state values
    state_t          state_nxt_s;
    logic [OW-1:0]   owner_nxt_s;
    logic [OW-1:0]   last_owner_nxt_s;
    logic [CW-1:0]   word_cnt_nxt_s;
    logic [WW-1:0]   wd_cnt_nxt_s;

    // Arbitration and owner-selected views of the requester inputs
    logic [NUM_REQ-1:0] active_s;
    logic [NUM_REQ-1:0] owner_dec_s;
    logic               pick_found_s;
    logic [OW-1:0]      pick_idx_s;
    logic               own_req_s;
    logic               own_we_s;
    logic               own_last_s;
    logic               own_active_s;
    logic [DSIZE-1:0]   own_wdata_s;
    logic [CW-1:0]      word_inc_s;
    logic               bulk_full_s;
    logic               wd_expire_s;

    assign active_s = req_i & we_i;

    // Round-robin search: first active index starting just after last_owner
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int cand;
            cand = (int'(last_owner_r) + 1 + i) % NUM_REQ;
            if (!pick_found_s && active_s[OW'(cand)]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = OW'(cand);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // One-hot decode of the current owner
    always_comb begin
        owner_dec_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            owner_dec_s[k] = (owner_r == OW'(k));
        end
    end

    // Mux the owner's request, enable, last marker and data slice
    always_comb begin
        own_wdata_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            own_wdata_s = own_wdata_s | (wdata_i[k*DSIZE +: DSIZE] & {DSIZE{owner_dec_s[k]}});
        end
        own_req_s    = |(req_i  & owner_dec_s);
        own_we_s     = |(we_i   & owner_dec_s);
        own_last_s   = |(last_i & owner_dec_s);
        own_active_s = own_req_s & own_we_s;
    end

    // Bulk-limit and watchdog conditions for the current cycle
    always_comb begin
        word_inc_s  = word_cnt_r + CW'(1);
        bulk_full_s = (word_inc_s == CW'(BULK_NUMBER));
        // >= rather than == so a counter pushed past the limit still releases
        wd_expire_s = !own_active_s && (wd_cnt_r >= WW'(WATCHDOG_LIMIT - 1));
    end

    // FSM next-state and port outputs; everything defaults to the idle values
    always_comb begin
        state_nxt_s      = state_r;
        owner_nxt_s      = owner_r;
        last_owner_nxt_s = last_owner_r;
        word_cnt_nxt_s   = word_cnt_r;
        wd_cnt_nxt_s     = wd_cnt_r;
        gnt_o            = '0;
        rvalid_o         = '0;
        ipr_req_o        = 1'b0;
        ipr_we_o         = 1'b0;
        ipr_wdata_o      = '0;
        timeout_o        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    owner_nxt_s    = pick_idx_s;
                    word_cnt_nxt_s = '0;
                    wd_cnt_nxt_s   = '0;
                    state_nxt_s    = ST_OWN;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end

            ST_OWN: begin
                ipr_req_o   = own_req_s;
                ipr_we_o    = own_we_s;
                ipr_wdata_o = own_wdata_s;
                gnt_o       = owner_dec_s & {NUM_REQ{ipr_gnt_i}};
                rvalid_o    = owner_dec_s & {NUM_REQ{ipr_rvalid_i}};

                // Watchdog counts consecutive cycles with the owner not writing
                if (own_active_s) begin
                    wd_cnt_nxt_s = '0;
                end else if (wd_cnt_r != WW'(WATCHDOG_LIMIT)) begin
                    wd_cnt_nxt_s = wd_cnt_r + WW'(1);
                end else begin
                    wd_cnt_nxt_s = wd_cnt_r;
                end

                if (ipr_gnt_i) begin
                    word_cnt_nxt_s = word_inc_s;
                    // last marker and bulk limit together still mean one DRAIN
                    if (own_last_s || bulk_full_s) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_OWN;
                    end
                end else if (wd_expire_s) begin
                    timeout_o        = 1'b1;
                    last_owner_nxt_s = owner_r;
                    state_nxt_s      = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OWN;
                end
            end

            ST_DRAIN: begin
                // Wait for the final word's response before releasing the port
                rvalid_o = owner_dec_s & {NUM_REQ{ipr_rvalid_i}};
                if (ipr_rvalid_i) begin
                    last_owner_nxt_s = owner_r;
                    state_nxt_s      = ST_IDLE;
                end else begin
                    state_nxt_s      = ST_DRAIN;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, owner, priority pointer and counters; index 0 has priority after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= '0;
            last_owner_r <= OW'(NUM_REQ - 1);
            word_cnt_r   <= '0;
            wd_cnt_r     <= '0;
        end else begin
            state_r      <= state_nxt_s;
            owner_r      <= owner_nxt_s;
            last_owner_r <= last_owner_nxt_s;
            word_cnt_r   <= word_cnt_nxt_s;
            wd_cnt_r     <= wd_cnt_nxt_s;
        end
    end

    assign owner_o = owner_r;
    assign busy_o  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_ipr_write_arb.sv
// tb_ipr_write_arb
// Directed bench: each test pushes its expected grants/responses/timeouts
// into queues; a negedge monitor pops and compares whenever the DUT presents
// gnt_o, rvalid_o or timeout_o. Requesters are small behavioural models.

module tb_ipr_write_arb;

    localparam int NUM_REQ = 4;
    localparam int DSIZE   = 32;

    typedef struct packed {
        logic [3:0]  gnt;
        logic [31:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_i = 4'b0;
    logic [3:0]   we_i = 4'b0;
    logic [3:0]   last_i = 4'b0;
    logic [127:0] wdata_i = 128'b0;
    logic [3:0]   gnt_o;
    logic [3:0]   rvalid_o;
    logic         ipr_req_o;
    logic         ipr_we_o;
    logic [31:0]  ipr_wdata_o;
    logic         ipr_gnt_i;
    logic         ipr_rvalid_i = 1'b0;
    logic [1:0]   owner_o;
    logic         busy_o;
    logic         timeout_o;
    logic         gnt_en = 1'b1;
    logic [3:0]   gnt_seen = 4'b0;

    int checks = 0;
    int passes = 0;

    exp_t       exp_gnt_q[$];
    logic [3:0] exp_rv_q[$];
    logic [1:0] exp_to_q[$];

    int words_left[4];
    int bulk_len[4];
    int bulk_pos[4];
    int seq[4];

    ipr_write_arb #(
        .NUM_REQ(4), .DSIZE(32), .BULK_NUMBER(10), .WATCHDOG_LIMIT(100)
    ) dut (
        .clk(clk), .rst(rst),
        .req_i(req_i), .we_i(we_i), .last_i(last_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .ipr_req_o(ipr_req_o), .ipr_we_o(ipr_we_o), .ipr_wdata_o(ipr_wdata_o),
        .ipr_gnt_i(ipr_gnt_i), .ipr_rvalid_i(ipr_rvalid_i),
        .owner_o(owner_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    // Downstream FIFO model: grants any write request, responds one cycle later
    assign ipr_gnt_i = gnt_en & ipr_req_o & ipr_we_o;
    always @(posedge clk) ipr_rvalid_i <= ipr_gnt_i;

    function automatic logic [31:0] mkdata(int k, int n);
        return {8'hA0 + 8'(k), 24'(n)};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else passes++;
    endtask

    task automatic exp_word(int k, int n);
        exp_t e;
        e.gnt  = 4'b0001 << k;
        e.data = mkdata(k, n);
        exp_gnt_q.push_back(e);
        exp_rv_q.push_back(4'b0001 << k);
    endtask

    task automatic exp_gnt_only(int k, int n);
        exp_t e;
        e.gnt  = 4'b0001 << k;
        e.data = mkdata(k, n);
        exp_gnt_q.push_back(e);
    endtask

    task automatic clear_req();
        for (int k = 0; k < 4; k++) begin
            words_left[k] = 0; bulk_len[k] = 0; bulk_pos[k] = 0; seq[k] = 0;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            req_i[k]  = (words_left[k] != 0);
            we_i[k]   = (words_left[k] != 0);
            last_i[k] = (words_left[k] != 0) && (bulk_len[k] != 0) && (bulk_pos[k] + 1 == bulk_len[k]);
            wdata_i[k*32 +: 32] = mkdata(k, seq[k]);
        end
    endtask

    task automatic start();
        drive();
        #1;
    endtask

    // Advance one cycle: requesters consume the grant seen last cycle
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (gnt_seen[k] && words_left[k] > 0) begin
                words_left[k]--;
                seq[k]++;
                if (bulk_len[k] != 0 && bulk_pos[k] + 1 == bulk_len[k]) bulk_pos[k] = 0;
                else bulk_pos[k]++;
            end
        end
        drive();
        #1;
    endtask

    task automatic chk_quiet(string name);
        chk({name, "_busy"}, 64'(busy_o), 64'd0);
        chk({name, "_ipr_req"}, 64'(ipr_req_o), 64'd0);
        chk({name, "_gnt"}, 64'(gnt_o), 64'd0);
        chk({name, "_rvalid"}, 64'(rvalid_o), 64'd0);
        chk({name, "_timeout"}, 64'(timeout_o), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        start();
        chk_quiet("reset");
        chk("reset_owner", 64'(owner_o), 64'd0);
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while ((exp_gnt_q.size() != 0 || exp_rv_q.size() != 0 || exp_to_q.size() != 0 || busy_o) && n < 400) begin
            tick();
            n++;
        end
        chk({name, "_done"}, 64'(n < 400), 64'd1);
    endtask

    // Monitor: compare DUT output events against the expectation queues
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            gnt_seen = gnt_o;
            if (|gnt_o) begin
                if (exp_gnt_q.size() == 0) chk("unexpected_gnt", 64'(gnt_o), 64'd0);
                else begin
                    e = exp_gnt_q.pop_front();
                    chk("gnt_vec", 64'(gnt_o), 64'(e.gnt));
                    chk("gnt_data", 64'(ipr_wdata_o), 64'(e.data));
                end
            end
            if (|rvalid_o) begin
                if (exp_rv_q.size() == 0) chk("unexpected_rvalid", 64'(rvalid_o), 64'd0);
                else chk("rvalid_vec", 64'(rvalid_o), 64'(exp_rv_q.pop_front()));
            end
            if (timeout_o) begin
                if (exp_to_q.size() == 0) chk("unexpected_timeout", 64'(timeout_o), 64'd0);
                else chk("timeout_owner", 64'(owner_o), 64'(exp_to_q.pop_front()));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        clear_req();
        do_reset();

        // Single requester: 3 words, last on the third
        clear_req();
        words_left[0] = 3; bulk_len[0] = 3;
        exp_word(0, 0); exp_word(0, 1); exp_word(0, 2);
        start();
        chk("single_c0_req", 64'(ipr_req_o), 64'd0);
        chk("single_c0_busy", 64'(busy_o), 64'd0);
        tick();
        chk("single_c1_req", 64'(ipr_req_o), 64'd1);
        chk("single_c1_busy", 64'(busy_o), 64'd1);
        chk("single_c1_owner", 64'(owner_o), 64'd0);
        tick(); tick(); tick();
        chk("single_drain_busy", 64'(busy_o), 64'd1);
        chk("single_drain_req", 64'(ipr_req_o), 64'd0);
        tick();
        chk("single_release_busy", 64'(busy_o), 64'd0);
        wait_idle("single");

        // last_owner is 0 now: simultaneous req0/req1 must grant 1 first
        clear_req();
        words_left[0] = 1; bulk_len[0] = 1;
        words_left[1] = 1; bulk_len[1] = 1;
        exp_word(1, 0); exp_word(0, 0);
        start();
        wait_idle("lastowner");

        // Fairness from reset: owners 0,1,2,3,0
        do_reset();
        clear_req();
        words_left[0] = 2; words_left[1] = 1; words_left[2] = 1; words_left[3] = 1;
        for (int k = 0; k < 4; k++) bulk_len[k] = 1;
        exp_word(0, 0); exp_word(1, 0); exp_word(2, 0); exp_word(3, 0); exp_word(0, 1);
        start();
        wait_idle("fair");

        // Bulk limit: req2 never asserts last -> 10 words, then owner 3
        clear_req();
        words_left[2] = 10;
        words_left[3] = 1; bulk_len[3] = 1;
        for (int i = 0; i < 10; i++) exp_word(2, i);
        exp_word(3, 0);
        start();
        wait_idle("bulk");

        // Backpressure: 20-cycle grant stall after 4 words, no timeout, 10 words total
        clear_req();
        words_left[1] = 10;
        words_left[2] = 1; bulk_len[2] = 1;
        for (int i = 0; i < 10; i++) exp_word(1, i);
        exp_word(2, 0);
        start();
        n = 0;
        while (seq[1] < 4 && n < 30) begin tick(); n++; end
        chk("bp_reach4", 64'(n < 30), 64'd1);
        gnt_en = 1'b0;
        repeat (20) tick();
        chk("bp_busy", 64'(busy_o), 64'd1);
        chk("bp_owner", 64'(owner_o), 64'd1);
        chk("bp_words", 64'(seq[1]), 64'd4);
        gnt_en = 1'b1;
        wait_idle("bp");

        // Watchdog: owner 1 stops after 2 words; req2 waiting
        clear_req();
        words_left[1] = 2;
        words_left[2] = 1; bulk_len[2] = 1;
        exp_word(1, 0); exp_word(1, 1);
        exp_to_q.push_back(2'd1);
        exp_word(2, 0);
        start();
        n = 0;
        while (words_left[1] != 0 && n < 20) begin tick(); n++; end
        chk("wd_drop", 64'(n < 20), 64'd1);
        n = 0;
        while (n < 150) begin
            n++;
            if (timeout_o) break;
            tick();
        end
        chk("wd_idle_cycles", 64'(n), 64'd100);
        tick();
        chk("wd_busy_after", 64'(busy_o), 64'd0);
        wait_idle("wd");

        // Reset mid-bulk with owner 3, then simultaneous req0/req3 grants 0
        clear_req();
        words_left[3] = 10;
        exp_word(3, 0); exp_word(3, 1); exp_gnt_only(3, 2);
        exp_word(0, 0); exp_word(3, 3);
        start();
        tick(); tick(); tick();
        rst = 1'b1;
        start();
        tick();
        rst = 1'b0;
        words_left[0] = 1; bulk_len[0] = 1; bulk_pos[0] = 0;
        words_left[3] = 1; bulk_len[3] = 1; bulk_pos[3] = 0;
        start();
        chk_quiet("rstmid");
        wait_idle("rstmid");

        chk("gnt_q_empty", 64'(exp_gnt_q.size()), 64'd0);
        chk("rv_q_empty", 64'(exp_rv_q.size()), 64'd0);
        chk("to_q_empty", 64'(exp_to_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
